alu_station: RTL

- Single-entry reservation station plus integer ALU. It is the receiving end of the dispatch issue interface, one instance per ALU slot (master and slave).
- Accepts one issued instruction with tagged operands and snoops the three write-back buses until both operands are unlocked.
- Executes in one cycle and broadcasts the result on its own write-back bus.
- Drives the busy flag that dispatch samples before issuing.

---
 rtl/alu_station.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_station.sv
// Single-entry reservation station with a one-cycle integer ALU.
// Holds one issued instruction, snoops three write-back buses for its operands and broadcasts the result.
module alu_station #(
    parameter int unsigned      TAG_W    = 2,
    parameter logic [TAG_W-1:0] UNLOCKED = TAG_W'(0),
    parameter logic [TAG_W-1:0] MY_TAG   = TAG_W'(1),
    parameter logic [TAG_W-1:0] BUS0_TAG = TAG_W'(1),
    parameter logic [TAG_W-1:0] BUS1_TAG = TAG_W'(2),
    parameter logic [TAG_W-1:0] BUS2_TAG = TAG_W'(3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear_in,
    input  logic             en_in,
    input  logic [3:0]       op_in,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      datax_in,
    input  logic [31:0]      datay_in,
    input  logic [TAG_W-1:0] tagx_in,
    input  logic [TAG_W-1:0] tagy_in,
    input  logic [4:0]       addrw_in,
    input  logic             en_mw0,
    input  logic             en_mw1,
    input  logic             en_mw2,
    input  logic [31:0]      write_data0,
    input  logic [31:0]      write_data1,
    input  logic [31:0]      write_data2,
    output logic             busy_out,
    output logic             en_mw_out,
    output logic [4:0]       reg_write_addr_out,
    output logic [31:0]      write_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_EXEC
    } state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SLT   = 4'd3,
        OP_SLTU  = 4'd4,
        OP_XOR   = 4'd5,
        OP_SRL   = 4'd6,
        OP_SRA   = 4'd7,
        OP_OR    = 4'd8,
        OP_AND   = 4'd9,
        OP_LUI   = 4'd10,
        OP_AUIPC = 4'd11,
        OP_LINK  = 4'd12
    } alu_op_e;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } operand_t;

    // This station's own results only reach it if MY_TAG names one of the snooped buses.
    if (MY_TAG != BUS0_TAG && MY_TAG != BUS1_TAG && MY_TAG != BUS2_TAG) begin : g_bad_my_tag
        $error("alu_station: MY_TAG does not match any write-back bus tag");
    end

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        en_mw_out_q, en_mw_out_d;
    logic [4:0]  reg_write_addr_q, reg_write_addr_d;
    logic [31:0] write_data_q, write_data_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  addrw_q, addrw_d;
    operand_t    opx_q, opx_d;
    operand_t    opy_q, opy_d;

    operand_t    issue_x, issue_y;
    operand_t    wait_x, wait_y;

    // An operand unlocks when the bus carrying its tag is valid in the same cycle.
    function automatic operand_t capture(input operand_t cur);
        operand_t res;
        res = cur;
        if (cur.tag != UNLOCKED) begin
            if (en_mw0 && cur.tag == BUS0_TAG) begin
                res.tag  = UNLOCKED;
                res.data = write_data0;
            end else if (en_mw1 && cur.tag == BUS1_TAG) begin
                res.tag  = UNLOCKED;
                res.data = write_data1;
            end else if (en_mw2 && cur.tag == BUS2_TAG) begin
                res.tag  = UNLOCKED;
                res.data = write_data2;
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] alu(input logic [3:0] op, input logic [31:0] x,
                                        input logic [31:0] y, input logic [31:0] pc);
        logic [4:0]  sh;
        logic [31:0] r;
        sh = y[4:0];
        r  = '0;
        case (alu_op_e'(op))
            OP_ADD:   r = x + y;
            OP_SUB:   r = x - y;
            OP_SLL:   r = x << sh;
            OP_SLT:   r = {31'd0, $signed(x) < $signed(y)};
            OP_SLTU:  r = {31'd0, x < y};
            OP_XOR:   r = x ^ y;
            OP_SRL:   r = x >> sh;
            OP_SRA:   r = $unsigned($signed(x) >>> sh);
            OP_OR:    r = x | y;
            OP_AND:   r = x & y;
            OP_LUI:   r = y;
            OP_AUIPC: r = pc + y;
            OP_LINK:  r = pc + 32'd4;
            default:  r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d          = state_q;
        busy_d           = busy_q;
        en_mw_out_d      = en_mw_out_q;
        reg_write_addr_d = reg_write_addr_q;
        write_data_d     = write_data_q;
        op_d             = op_q;
        pc_d             = pc_q;
        addrw_d          = addrw_q;
        opx_d            = opx_q;
        opy_d            = opy_q;

        issue_x = capture('{tag: tagx_in, data: datax_in});
        issue_y = capture('{tag: tagy_in, data: datay_in});
        wait_x  = capture(opx_q);
        wait_y  = capture(opy_q);

        if (rdy) begin
            en_mw_out_d = 1'b0;
            if (clear_in) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (en_in) begin
                            op_d    = op_in;
                            pc_d    = pc_in;
                            addrw_d = addrw_in;
                            opx_d   = issue_x;
                            opy_d   = issue_y;
                            busy_d  = 1'b1;
                            state_d = (issue_x.tag == UNLOCKED && issue_y.tag == UNLOCKED)
                                      ? ST_EXEC : ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        opx_d = wait_x;
                        opy_d = wait_y;
                        if (wait_x.tag == UNLOCKED && wait_y.tag == UNLOCKED) begin
                            state_d = ST_EXEC;
                        end
                    end
                    ST_EXEC: begin
                        write_data_d     = alu(op_q, opx_q.data, opy_q.data, pc_q);
                        reg_write_addr_d = addrw_q;
                        en_mw_out_d      = 1'b1;
                        busy_d           = 1'b0;
                        state_d          = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            busy_q           <= 1'b0;
            en_mw_out_q      <= 1'b0;
            reg_write_addr_q <= '0;
            write_data_q     <= '0;
            op_q             <= '0;
            pc_q             <= '0;
            addrw_q          <= '0;
            opx_q            <= '{tag: UNLOCKED, data: 32'd0};
            opy_q            <= '{tag: UNLOCKED, data: 32'd0};
        end else begin
            // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
            state_q          <= state_d;
            busy_q           <= busy_d;
            en_mw_out_q      <= en_mw_out_d;
            reg_write_addr_q <= reg_write_addr_d;
            write_data_q     <= write_data_d;
            op_q             <= op_d;
            pc_q             <= pc_d;
            addrw_q          <= addrw_d;
            opx_q            <= opx_d;
            opy_q            <= opy_d;
        end
    end

    assign busy_out           = busy_q;
    assign en_mw_out          = en_mw_out_q;
    assign reg_write_addr_out = reg_write_addr_q;
    assign write_data_out     = write_data_q;

endmodule
